// File: rtl/router_reg.sv
// Router register block: header/payload/parity byte path to the destination FIFO, running parity and error flag.
// Optional saturating error counter output err_cnt when ROUTER_REG_ERR_CNT_EN is defined.
module router_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  input  logic       fifo_full,
  input  logic       detect_addr,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err
`ifdef ROUTER_REG_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  logic [7:0] hdr;
  logic [7:0] full_byte;
  logic [7:0] int_par;
  logic [7:0] pkt_par;
  logic       err_nxt;

  // Address 2'b11 is not a valid destination, so that header is never latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr <= 8'h00;
    end else if (detect_addr && pkt_valid && (data_in[1:0] != 2'b11)) begin
      hdr <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 8'h00;
    end else if (lfd_state) begin
      dout <= hdr;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (laf_state) begin
      dout <= full_byte;
    end
  end

  // Byte stalled by a full FIFO is replayed later from laf_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_byte <= 8'h00;
    end else if (ld_state && fifo_full) begin
      full_byte <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_par <= 8'h00;
    end else if (detect_addr) begin
      int_par <= 8'h00;
    end else if (lfd_state) begin
      int_par <= int_par ^ hdr;
    end else if (ld_state && pkt_valid && !full_state) begin
      int_par <= int_par ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_par <= 8'h00;
    end else if (detect_addr) begin
      pkt_par <= 8'h00;
    end else if (ld_state && !pkt_valid) begin
      pkt_par <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_done <= 1'b0;
    end else if (detect_addr) begin
      parity_done <= 1'b0;
    end else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_comb begin
    err_nxt = err;
    if (detect_addr) begin
      err_nxt = 1'b0;
    end else if (parity_done) begin
      err_nxt = (int_par != pkt_par);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end

`ifdef ROUTER_REG_ERR_CNT_EN
  // Counts rising edges of err, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'h00;
    end else if (!err && err_nxt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: vector table plus reset, bad-address and error-counter sequences.
module tb_router_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       pkt_valid, fifo_full;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
`ifdef ROUTER_REG_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  router_reg dut (
    .clk(clk), .rst(rst), .data_in(data_in), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .err(err)
`ifdef ROUTER_REG_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // State-input encoding: {detect_addr, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] DET  = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] FST  = 6'b000010;
  localparam logic [5:0] RSTI = 6'b000001;

  typedef struct {
    logic [5:0] st;
    logic       pv;
    logic       ff;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_pd;
    logic       e_lpv;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] st, input logic pv, input logic ff,
                              input logic [7:0] din, input logic [7:0] e_dout,
                              input logic e_pd, input logic e_lpv, input logic e_err);
    vec_t v;
    v.st = st; v.pv = pv; v.ff = ff; v.din = din;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] st, input logic pv, input logic ff, input logic [7:0] din);
    {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    fifo_full = ff;
    data_in   = din;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v.st, v.pv, v.ff, v.din);
    @(posedge clk);
    #1;
    chk({tag, ".dout"}, dout, v.e_dout);
    chk({tag, ".parity_done"}, {7'd0, parity_done}, {7'd0, v.e_pd});
    chk({tag, ".low_pkt_valid"}, {7'd0, low_pkt_valid}, {7'd0, v.e_lpv});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, v.e_err});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".dout"}, dout, 8'h00);
    chk({tag, ".parity_done"}, {7'd0, parity_done}, 8'h00);
    chk({tag, ".low_pkt_valid"}, {7'd0, low_pkt_valid}, 8'h00);
    chk({tag, ".err"}, {7'd0, err}, 8'h00);
  endtask

  initial begin
    rst = 1'b0;
    drive(IDLE, 1'b0, 1'b0, 8'h00);
    #3;
    check_all_zero("reset");
`ifdef ROUTER_REG_ERR_CNT_EN
    chk("reset.err_cnt", err_cnt, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b1;

    // good packet 05/A3, parity A6
    tbl.push_back(mk(DET,       1, 0, 8'h05, 8'h00, 0, 0, 0));
    tbl.push_back(mk(LFD,       1, 0, 8'hA3, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LD,        1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    tbl.push_back(mk(LD,        0, 0, 8'hA6, 8'hA6, 1, 1, 0));
    tbl.push_back(mk(RSTI,      0, 0, 8'h00, 8'hA6, 1, 0, 0));
    // bad parity byte 00: err one cycle after parity_done, held until detect_addr
    tbl.push_back(mk(DET,       1, 0, 8'h05, 8'hA6, 0, 0, 0));
    tbl.push_back(mk(LFD,       1, 0, 8'hA3, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LD,        1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    tbl.push_back(mk(LD,        0, 0, 8'h00, 8'h00, 1, 1, 0));
    tbl.push_back(mk(IDLE,      0, 0, 8'h00, 8'h00, 1, 1, 1));
    tbl.push_back(mk(IDLE,      0, 0, 8'h00, 8'h00, 1, 1, 1));
    // FIFO full on payload 3C, replayed from laf; parity 05^3C=39
    tbl.push_back(mk(DET|RSTI,  1, 0, 8'h05, 8'h00, 0, 0, 0));
    tbl.push_back(mk(LFD,       1, 0, 8'h3C, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LD,        1, 1, 8'h3C, 8'h05, 0, 0, 0));
    tbl.push_back(mk(FST,       1, 1, 8'h3C, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LAF,       1, 0, 8'h3C, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(LD,        0, 0, 8'h39, 8'h39, 1, 1, 0));
    tbl.push_back(mk(RSTI,      0, 0, 8'h00, 8'h39, 1, 0, 0));
    // FIFO full on the parity byte: parity_done set from laf path
    tbl.push_back(mk(DET,       1, 0, 8'h05, 8'h39, 0, 0, 0));
    tbl.push_back(mk(LFD,       1, 0, 8'hA3, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LD,        1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    tbl.push_back(mk(LD,        0, 1, 8'hA6, 8'hA3, 0, 1, 0));
    tbl.push_back(mk(FST,       0, 1, 8'hA6, 8'hA3, 0, 1, 0));
    tbl.push_back(mk(LAF,       0, 0, 8'h00, 8'hA6, 1, 1, 0));
    tbl.push_back(mk(RSTI,      0, 0, 8'h00, 8'hA6, 1, 0, 0));
    // simultaneous state inputs resolve by priority
    tbl.push_back(mk(DET|LFD|LD, 1, 0, 8'h09, 8'h05, 0, 0, 0));
    tbl.push_back(mk(LFD|LD|LAF, 0, 0, 8'h11, 8'h09, 1, 1, 0));
    tbl.push_back(mk(IDLE,       0, 0, 8'h00, 8'h09, 1, 1, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // address 2'b11 header dropped: header register keeps 09
    apply(mk(DET|RSTI, 1, 0, 8'h07, 8'h09, 0, 0, 0), "addr11.det");
    apply(mk(LFD,      1, 0, 8'hA3, 8'h09, 0, 0, 0), "addr11.lfd");
    apply(mk(IDLE,     0, 0, 8'h00, 8'h09, 0, 0, 0), "addr11.idle");

    // reset pulsed mid-packet, checked before any clock edge
    apply(mk(DET,  1, 0, 8'h05, 8'h09, 0, 0, 0), "mid.det");
    apply(mk(LFD,  1, 0, 8'hA3, 8'h05, 0, 0, 0), "mid.lfd");
    apply(mk(LD,   1, 0, 8'hA3, 8'hA3, 0, 0, 0), "mid.ld");
    apply(mk(LD,   0, 1, 8'h5A, 8'hA3, 0, 1, 0), "mid.ld_low");
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    drive(IDLE, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(DET,  1, 0, 8'h05, 8'h00, 0, 0, 0), "post.det");
    apply(mk(LFD,  1, 0, 8'hA3, 8'h05, 0, 0, 0), "post.lfd");
    apply(mk(LD,   1, 0, 8'hA3, 8'hA3, 0, 0, 0), "post.ld");
    apply(mk(LD,   0, 0, 8'hA6, 8'hA6, 1, 1, 0), "post.par");
    apply(mk(RSTI, 0, 0, 8'h00, 8'hA6, 1, 0, 0), "post.err");

`ifdef ROUTER_REG_ERR_CNT_EN
    for (int p = 0; p < 257; p++) begin
      drive(DET|RSTI, 1'b1, 1'b0, 8'h05); @(posedge clk);
      drive(LFD, 1'b1, 1'b0, 8'hA3);      @(posedge clk);
      drive(LD, 1'b1, 1'b0, 8'hA3);       @(posedge clk);
      drive(LD, 1'b0, 1'b0, 8'h00);       @(posedge clk);
      drive(IDLE, 1'b0, 1'b0, 8'h00);     @(posedge clk);
      #1;
      if (p == 0) chk("cnt.first", err_cnt, 8'h01);
      if (p == 1) chk("cnt.second", err_cnt, 8'h02);
    end
    chk("cnt.sat", err_cnt, 8'hFF);
    chk("cnt.err", {7'd0, err}, 8'h01);
    rst = 1'b0;
    #1;
    chk("cnt.reset", err_cnt, 8'h00);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_reg.md
ROUTER_REG -- requirements
Module: router_reg

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1; asynchronous, active-low reset.
REQ-003 SHALL have port data_in, input, 8, the input byte stream (header, payload, parity).
REQ-004 SHALL have port pkt_valid, input, 1; high while header or payload is on data_in, low on the parity byte.
REQ-005 SHALL have port fifo_full, input, 1, the destination FIFO full flag.
REQ-006 SHALL have FSM-state inputs, each 1 bit: detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
REQ-007 SHALL have port dout, output, 8, the byte presented to the destination FIFO.
REQ-008 SHALL have port parity_done, output, 1, meaning the parity byte has been captured.
REQ-009 SHALL have port low_pkt_valid, output, 1, meaning pkt_valid fell during a load.
REQ-010 SHALL have port err, output, 1, meaning a packet parity mismatch.

Function
REQ-011 SHALL hold an internal header register. It captures data_in when detect_addr && pkt_valid && data_in[1:0]!=2'b11; otherwise it holds.
REQ-012 SHALL update dout by first-match priority:
- lfd_state: dout <= header register.
- ld_state && !fifo_full: dout <= data_in.
- laf_state: dout <= full-byte register.
- otherwise: dout holds.
REQ-013 SHALL hold an internal full-byte register that captures data_in when ld_state && fifo_full, so the byte stalled on FIFO full is replayed in laf_state.
REQ-014 SHALL update the running internal parity (8 bits) by first-match priority:
- detect_addr: cleared to 0.
- lfd_state: XOR with the header register.
- ld_state && pkt_valid && !full_state: XOR with data_in.
- otherwise: holds.
REQ-015 SHALL hold a packet-parity register (8 bits). It captures data_in when ld_state && !pkt_valid, is cleared by detect_addr, and otherwise holds.
REQ-016 SHALL update parity_done by first-match priority:
- detect_addr: 0.
- (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done): 1.
- otherwise: holds.
REQ-017 SHALL update low_pkt_valid by first-match priority:
- rst_int_reg: 0.
- ld_state && !pkt_valid: 1.
- otherwise: holds.
REQ-018 SHALL update err by first-match priority:
- detect_addr: 0.
- parity_done==1: err <= (internal parity != packet parity).
- otherwise: holds.
REQ-019 SHALL make err valid on the edge after parity_done rises (latency 1 cycle); err stays stable until the next detect_addr.
REQ-020 SHALL drop the header byte when address 2'b11 is presented: no header capture and no parity change from it; the FSM does not leave decode for it.
REQ-021 SHALL resolve simultaneous assertion of several state inputs by the priority order given in each requirement; no output shall become X.

Reset
REQ-022 SHALL, while rst==0 (asynchronous, independent of clk), clear dout, parity_done, low_pkt_valid, err, the header register, the full-byte register, internal parity and packet parity to 0.
REQ-023 SHALL, on rst asserted mid-packet, discard all packet state; the first packet after release is handled as a fresh packet.

Configuration
REQ-024 SHALL support macro ROUTER_REG_ERR_CNT_EN.
- When defined: output err_cnt (8 bits, reset 0) is added. It increments by 1 on each 0->1 transition of err and saturates at 8'hFF.
- When undefined: err_cnt and its logic are absent, and all other behaviour is unchanged.

Verification
REQ-025 Good packet: header 8'h05, payload 8'hA3 (pkt_valid=1), parity 8'hA6 (pkt_valid=0), no fifo_full -> dout sequence 05, A3; parity_done=1; err=0.
REQ-026 Bad parity: same packet with parity byte 8'h00 -> err=1 one cycle after parity_done; err cleared by the next detect_addr.
REQ-027 FIFO full: fifo_full=1 in ld_state while payload 8'h3C is on data_in -> dout holds; after full_state, laf_state drives dout=3C; parity still matches, so err=0.
REQ-028 Reset mid-packet: rst pulsed low during ld_state -> all outputs read 0 immediately, before any clk edge; the next good packet gives err=0.
REQ-029 Address 2'b11: detect_addr with data_in=8'h07 -> header register and internal parity unchanged.
REQ-030 ROUTER_REG_ERR_CNT_EN defined: 257 bad-parity packets -> err_cnt=8'hFF with no wrap; rst clears err_cnt to 0.
